nano_uart_tx: RTL and testbench

Byte-serial UART transmitter that consumes output bytes written by the nano_top CPU's I/O port and drives a single-wire asynchronous serial line (8N1, LSB first). Sits directly downstream of the CPU, beside the LED output. It decouples CPU write bursts from line rate through a small FIFO and exposes `full` and `busy` so firmware can poll before writing.

---
 rtl/nano_pkg.sv | 14 +
 rtl/nano_fifo.sv | 61 ++++++
 rtl/nano_uart_tx.sv | 125 ++++++++++++
 tb/tb_nano_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared definitions for the nano_top peripherals.
package nano_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/nano_fifo.sv
// Single-clock FIFO with occupancy counter. Pushes when full and pops when
// empty are ignored, so callers may leave the strobes unguarded.
module nano_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     sreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: the storage array is deliberately left out of reset; the level
    // counter already marks every entry invalid, and a reset RAM cannot map
    // onto block or distributed memory.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of the order of statements and processes.
    always_ff @(posedge clock or posedge sreset) begin
        if (sreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);

endmodule

// File: rtl/nano_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back to back while
// the FIFO has data.
module nano_uart_tx
    import nano_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          sreset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          txd
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_DATA  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP  = 3'(UART_STOP_BITS - 1);

    uart_state_t   state;
    uart_state_t   state_next;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          fifo_empty;
    logic          pop;
    logic          bit_end;

    nano_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .sreset    (sreset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign bit_end = (timer == '0);

    always_ff @(posedge clock or posedge sreset) begin
        if (sreset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a value held and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_idx == LAST_DATA) state_next = STOP;
            STOP: begin
                // Popping on the last stop cycle keeps consecutive frames contiguous.
                if (bit_end && bit_idx == LAST_STOP) begin
                    if (!fifo_empty) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge sreset) begin
        if (sreset) begin
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full) overflow <= 1'b1;
            if (pop) begin
                shift <= head;
                timer <= TIMER_LOAD;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    timer <= TIMER_LOAD;
                    case (state)
                        DATA: begin
                            shift   <= shift >> 1;
                            bit_idx <= (bit_idx == LAST_DATA) ? 3'd0 : bit_idx + 3'd1;
                        end
                        STOP:    bit_idx <= (bit_idx == LAST_STOP) ? 3'd0 : bit_idx + 3'd1;
                        default: bit_idx <= 3'd0;
                    endcase
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

    // txd depends only on state, so reset drives the line high without a clock.
    always_comb begin
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift[0];
            default: txd = 1'b1;
        endcase
        busy = (state != IDLE) || (level != '0);
    end

endmodule

// File: tb/tb_nano_uart_tx.sv
// Randomised bench for nano_uart_tx: a frame-level line model plus a serial
// monitor that decodes txd back into bytes.
module tb_nano_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic                      clock = 1'b0;
    logic                      sreset;
    logic                      wr_en;
    logic [7:0]                wr_data;
    logic                      full;
    logic [$clog2(DEPTH):0]    level;
    logic                      busy;
    logic                      overflow;
    logic                      txd;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queued bytes, byte on the line, cycles left in its frame.
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx[$];
    logic [7:0] mcur;
    int         mline;
    bit         movf;

    bit         mon_on;
    int         mon_k;
    logic [7:0] mon_byte;
    int         lvl_peak;

    nano_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .sreset   (sreset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .txd      (txd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int p;
        int idx;
        if (mline == 0) return 1'b1;
        p   = FRAME - mline;
        idx = p / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return mcur[idx-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mline  = 0;
        movf   = 1'b0;
        mon_on = 1'b0;
        mon_k  = 0;
    endtask

    // One clock edge of the reference: frame ends, pop, then guarded push.
    task automatic model_edge(input bit we, input logic [7:0] d);
        int pre_size;
        pre_size = mq.size();
        if (mline == 1) exp_rx.push_back(mcur);
        if (mline <= 1 && pre_size != 0) begin
            mcur  = mq.pop_front();
            mline = FRAME;
        end else if (mline != 0) begin
            mline--;
        end
        if (we) begin
            if (pre_size < DEPTH) mq.push_back(d);
            else                  movf = 1'b1;
        end
    endtask

    task automatic sample();
        check("txd", txd, exp_txd());
        check("level", level, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("busy", busy, (mline != 0) || (mq.size() != 0));
        check("overflow", overflow, movf);
        if (int'(level) > lvl_peak) lvl_peak = int'(level);
        if (!mon_on) begin
            if (txd == 1'b0) begin
                mon_on = 1'b1;
                mon_k  = 1;
            end
        end else begin
            if (mon_k == CPB / 2) check("mon_start", txd, 1'b0);
            if (mon_k >= CPB && mon_k < 9 * CPB && (mon_k % CPB) == CPB / 2)
                mon_byte[mon_k/CPB-1] = txd;
            if (mon_k == 9 * CPB + CPB / 2) check("mon_stop", txd, 1'b1);
            if (mon_k == FRAME - 1) begin
                rx.push_back(mon_byte);
                mon_on = 1'b0;
            end else begin
                mon_k++;
            end
        end
    endtask

    task automatic cycle(input bit we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clock);
        model_edge(we, d);
        @(negedge clock);
        sample();
    endtask

    task automatic drain();
        int n = 0;
        while ((mline != 0 || mq.size() != 0) && n < 2000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("drain_bound", n < 2000, 1'b1);
    endtask

    task automatic wait_line(input int target, input string tag);
        int n = 0;
        while (mline != target && n < 500) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check(tag, n < 500, 1'b1);
    endtask

    initial begin
        bit pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int sent;
        int n;

        sreset  = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clock);
        sample();
        sreset = 1'b0;
        cycle(1'b0, 8'h00);

        // Single byte: bit pattern and busy release after 40 line cycles.
        cycle(1'b1, 8'hA5);
        check("a5_level", level, 1);
        check("a5_txd_idle", txd, 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            cycle(1'b0, 8'h00);
            check("a5_bit", txd, pat[c/CPB]);
        end
        check("a5_busy_last", busy, 1'b1);
        cycle(1'b0, 8'h00);
        check("a5_busy_end", busy, 1'b0);

        // Burst of three: contiguous frames, peak occupancy of two.
        lvl_peak = 0;
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'h55);
        drain();
        check("burst_peak", lvl_peak, 2);

        // Push lands on the final stop cycle while one byte is queued.
        cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'hC3);
        wait_line(1, "simul_wait");
        cycle(1'b1, 8'h81);
        check("simul_level", level, 1);
        check("simul_start", txd, 1'b0);
        drain();

        // Six writes into an idle block: five accepted, sixth dropped.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
        check("ovf_full", full, 1'b1);
        check("ovf_flag", overflow, 1'b1);
        drain();
        check("ovf_sticky", overflow, 1'b1);

        // Twenty bytes through the depth-4 FIFO to wrap the pointers.
        sent = 0;
        n    = 0;
        while (sent < 20 && n < 5000) begin
            if (mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                cycle(1'b1, 8'($urandom));
                sent++;
            end else begin
                cycle(1'b0, 8'h00);
            end
            n++;
        end
        check("wrap_bound", n < 5000, 1'b1);
        drain();

        // Free-running random writes, including writes while full.
        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) == 0, 8'($urandom));
        drain();

        // Reset during data bit 3 with two bytes queued.
        cycle(1'b1, 8'h96);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        wait_line(FRAME - (4 * CPB + 1), "rst_wait");
        check("rst_queued", level, 2);
        #2 sreset = 1'b1;
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        model_reset();
        @(negedge clock);
        sreset = 1'b0;
        sample();
        for (int i = 0; i < 3 * FRAME; i++) cycle(1'b0, 8'h00);

        check("rx_count", rx.size(), exp_rx.size());
        for (int i = 0; i < rx.size() && i < exp_rx.size(); i++)
            check("rx_byte", rx[i], exp_rx[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
